// File: rtl/fetch_queue_unit.sv
// Instruction-fetch queue: credit-limited imem request/grant/response port, in-order {pc, inst} FIFO toward ID.
// Optional macro IF_JAL_PREDECODE_EN redirects fetch on JAL at push time instead of waiting for downstream.
module fetch_queue_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  id_valid,
  output logic [PC_WIDTH-1:0]   id_pc,
  output logic [INST_WIDTH-1:0] id_inst,
  input  logic                  id_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0]   fetch_pc, resp_pc;
  logic [CW-1:0]         live_cnt, drop_cnt, fifo_count;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [PC_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];
  logic [CW+1:0]         credit_sum;
  logic                  issue, resp_keep, resp_drop, push, pop, fifo_empty;
  logic                  jal_hit;
  logic [PC_WIDTH-1:0]   jal_target;

  assign fifo_empty = (fifo_count == '0);
  // Entries held plus every outstanding response (kept or dropped) never exceed the queue size.
  assign credit_sum = (CW+2)'(fifo_count) + (CW+2)'(live_cnt) + (CW+2)'(drop_cnt);
  assign imem_req   = rst_n && !redirect_valid && (credit_sum < (CW+2)'(FIFO_DEPTH));
  assign imem_addr  = fetch_pc;
  assign issue      = imem_req && imem_gnt;
  assign resp_drop  = imem_rvalid && (drop_cnt != '0);
  assign resp_keep  = imem_rvalid && (drop_cnt == '0);
  assign push       = resp_keep && !redirect_valid;
  assign id_valid   = !fifo_empty && !redirect_valid;
  assign id_pc      = pc_mem[rd_ptr];
  assign id_inst    = inst_mem[rd_ptr];
  assign pop        = id_valid && id_ready;

`ifdef IF_JAL_PREDECODE_EN
  function automatic logic [PC_WIDTH-1:0] jal_offset(input logic [INST_WIDTH-1:0] inst);
    logic [20:0] imm;
    imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return {{(PC_WIDTH-21){imm[20]}}, imm};
  endfunction

  assign jal_hit    = push && (imem_rdata[6:0] == 7'b1101111);
  assign jal_target = resp_pc + jal_offset(imem_rdata);
`else
  assign jal_hit    = 1'b0;
  assign jal_target = resp_pc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      live_cnt   <= '0;
      drop_cnt   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= redirect_pc;
      resp_pc    <= redirect_pc;
      live_cnt   <= '0;
      drop_cnt   <= drop_cnt + live_cnt - CW'(resp_keep) - CW'(resp_drop);
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + STEP;
      if (push)  resp_pc  <= resp_pc + STEP;
      if (jal_hit) begin
        // A request granted on this same edge belongs to the old path and is dropped too.
        fetch_pc <= jal_target;
        resp_pc  <= jal_target;
        live_cnt <= '0;
        drop_cnt <= drop_cnt + live_cnt - CW'(1) + CW'(issue);
      end else begin
        live_cnt <= live_cnt + CW'(issue) - CW'(push);
        drop_cnt <= drop_cnt - CW'(resp_drop);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= imem_rdata;
    end
  end

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (live_cnt != '0 || drop_cnt != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (fifo_count < CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: per-cycle vector table plus hand sequences for stall, redirect and JAL cases.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        gnt_en = 1'b0;
  logic        rv_en = 1'b0;
  logic        id_ready = 1'b0;
  bit          jal_mode = 1'b0;

  logic        a_req, a_rvalid = 1'b0, a_id_valid;
  logic [31:0] a_addr, a_rdata = '0, a_id_pc, a_id_inst;
  logic        w_req, w_rvalid = 1'b0, w_id_valid;
  logic [31:0] w_addr, w_rdata = '0, w_id_pc, w_id_inst;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } pop_t;
  logic [31:0] qa[$], qw[$], grants[$];
  pop_t        pops[$];

  always #5 clk = ~clk;

  fetch_queue_unit dut_a (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(gnt_en), .imem_rvalid(a_rvalid),
    .imem_rdata(a_rdata), .id_valid(a_id_valid), .id_pc(a_id_pc), .id_inst(a_id_inst),
    .id_ready(id_ready)
  );

  fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(gnt_en), .imem_rvalid(w_rvalid),
    .imem_rdata(w_rdata), .id_valid(w_id_valid), .id_pc(w_id_pc), .id_inst(w_id_inst),
    .id_ready(id_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (jal_mode && addr == 32'h10) ? 32'h1000_006F : addr;
  endfunction

  // Memory model (in-order, responses no earlier than the cycle after grant) and ID-side monitor.
  always @(posedge clk) begin
    if (!rst_n) begin
      qa.delete();
      qw.delete();
    end else begin
      if (a_rvalid) void'(qa.pop_front());
      if (w_rvalid) void'(qw.pop_front());
      if (a_req && gnt_en) begin
        qa.push_back(a_addr);
        grants.push_back(a_addr);
      end
      if (w_req && gnt_en) qw.push_back(w_addr);
      if (a_id_valid && id_ready) pops.push_back('{a_id_pc, a_id_inst});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit g, input bit rv, input bit rdy, input bit redir, input logic [31:0] rpc);
    @(negedge clk);
    gnt_en         = g;
    rv_en          = rv;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    a_rvalid = rv && qa.size() > 0;
    a_rdata  = a_rvalid ? mem_word(qa[0]) : 32'h0;
    w_rvalid = rv && qw.size() > 0;
    w_rdata  = w_rvalid ? qw[0] : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    jal_mode = 1'b0;
    repeat (2) cyc(0, 0, 0, 0, 32'h0);
    check("rst_imem_req", {31'h0, a_req}, 32'h0);
    check("rst_id_valid", {31'h0, a_id_valid}, 32'h0);
    check("rst_imem_addr", a_addr, 32'h0);
    check("rst_imem_addr_wrap", w_addr, 32'hFFFF_FFF8);
    rst_n = 1'b1;
    pops.delete();
    grants.delete();
  endtask

  typedef struct {
    bit          g, rv, rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_wpc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1, 1, 1, 1, 32'h00, 0, 32'h0, 32'h0};
    vecs[1] = '{1, 1, 1, 1, 32'h04, 0, 32'h0, 32'h0};
    vecs[2] = '{1, 1, 1, 1, 32'h08, 1, 32'h0, 32'hFFFF_FFF8};
    vecs[3] = '{1, 1, 1, 1, 32'h0C, 1, 32'h4, 32'hFFFF_FFFC};
    vecs[4] = '{1, 1, 1, 1, 32'h10, 1, 32'h8, 32'h0000_0000};
    vecs[5] = '{1, 1, 1, 1, 32'h14, 1, 32'hC, 32'h0000_0004};

    // Streaming fetch, including PC wrap on the second instance.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(vecs[i].g, vecs[i].rv, vecs[i].rdy, 0, 32'h0);
      check($sformatf("v%0d_req", i), {31'h0, a_req}, {31'h0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i), a_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), {31'h0, a_id_valid}, {31'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i), a_id_pc, vecs[i].exp_pc);
        check($sformatf("v%0d_inst", i), a_id_inst, vecs[i].exp_pc);
        check($sformatf("v%0d_wvalid", i), {31'h0, w_id_valid}, 32'h1);
        check($sformatf("v%0d_wpc", i), w_id_pc, vecs[i].exp_wpc);
      end
    end

    // ID stalled: credit limit stops issue at FIFO_DEPTH, then drains in order.
    do_reset();
    repeat (10) cyc(1, 1, 0, 0, 32'h0);
    check("stall_grants", grants.size(), 32'd4);
    check("stall_req_low", {31'h0, a_req}, 32'h0);
    check("stall_head_pc", a_id_pc, 32'h0);
    grants.delete();
    pops.delete();
    repeat (6) cyc(1, 1, 1, 0, 32'h0);
    check("drain_count_ge4", {31'h0, pops.size() >= 4}, 32'h1);
    for (int i = 0; i < 4 && i < pops.size(); i++)
      check($sformatf("drain_pc%0d", i), pops[i].pc, 32'(i * 4));
    check("resume_grant", grants.size() > 0 ? grants[0] : 32'hDEAD_BEEF, 32'h10);

    // Redirect with two responses outstanding: both are discarded.
    do_reset();
    repeat (2) cyc(1, 0, 1, 0, 32'h0);
    cyc(0, 0, 1, 1, 32'h100);
    check("redir_req_low", {31'h0, a_req}, 32'h0);
    pops.delete();
    repeat (8) cyc(1, 1, 1, 0, 32'h0);
    check("redir_pop_count_ge2", {31'h0, pops.size() >= 2}, 32'h1);
    check("redir_first_pc", pops.size() > 0 ? pops[0].pc : 32'hDEAD_BEEF, 32'h100);
    check("redir_first_inst", pops.size() > 0 ? pops[0].inst : 32'hDEAD_BEEF, 32'h100);
    check("redir_second_pc", pops.size() > 1 ? pops[1].pc : 32'hDEAD_BEEF, 32'h104);

    // Redirect coinciding with rvalid and a ready ID stage.
    do_reset();
    repeat (2) cyc(1, 1, 1, 0, 32'h0);
    pops.delete();
    cyc(1, 1, 1, 1, 32'h200);
    check("redir_rv_valid_masked", {31'h0, a_id_valid}, 32'h0);
    cyc(1, 1, 1, 0, 32'h0);
    check("redir_rv_no_pop", pops.size(), 32'd0);
    check("redir_rv_empty", {31'h0, a_id_valid}, 32'h0);
    check("redir_rv_req", {31'h0, a_req}, 32'h1);
    check("redir_rv_addr", a_addr, 32'h200);
    repeat (4) cyc(1, 1, 1, 0, 32'h0);
    check("redir_rv_first_pc", pops.size() > 0 ? pops[0].pc : 32'hDEAD_BEEF, 32'h200);

`ifdef IF_JAL_PREDECODE_EN
    // JAL at 0x10 (offset +0x100) steers fetch to 0x110 and drops the younger response.
    do_reset();
    jal_mode = 1'b1;
    repeat (12) cyc(1, 1, 1, 0, 32'h0);
    begin
      logic [31:0] exp_seq [7];
      exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h110, 32'h114};
      check("jal_pop_count_ge7", {31'h0, pops.size() >= 7}, 32'h1);
      for (int i = 0; i < 7 && i < pops.size(); i++) begin
        check($sformatf("jal_pc%0d", i), pops[i].pc, exp_seq[i]);
        check($sformatf("jal_inst%0d", i), pops[i].inst, mem_word(exp_seq[i]));
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
